// File: rtl/mem_bus_pkg.sv
// ============================================================================
// Module  : mem_bus_pkg
// Brief   : Shared types and helpers for the memory-bus decode fabric.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Slave index width covers the 16-slave ceiling of the fabric.
    localparam int SEL_W = 4;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    // A disabled timeout still gets a 1-bit counter so no zero-width vectors appear.
    function automatic int cnt_w(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

    // Returns {found, index}; the lowest set bit wins.
    function automatic logic [SEL_W:0] onehot_prio(input logic [15:0] hits);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (hits[i]) begin
                r = {1'b1, SEL_W'(i)};
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_addr_decode.sv
// ============================================================================
// Module  : mem_bus_addr_decode
// Brief   : Combinational base/mask address decoder with lowest-index priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_addr_decode
    import mem_bus_pkg::*;
#(
    parameter int                            NUM_SLAVES = 4,
    parameter int                            ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_MASK   = '0
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [SEL_W-1:0]  o_sel
);

    logic [15:0]    w_hits;
    logic [SEL_W:0] w_prio;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_hit
            if (gi < NUM_SLAVES) begin : g_slv
                assign w_hits[gi] = ((i_addr & SLV_MASK[gi*ADDR_W +: ADDR_W])
                                     == SLV_BASE[gi*ADDR_W +: ADDR_W]);
            end else begin : g_pad
                assign w_hits[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_prio = onehot_prio(w_hits);
    assign o_hit  = w_prio[SEL_W];
    assign o_sel  = w_prio[SEL_W-1:0];

endmodule

`default_nettype wire

// File: rtl/mem_bus_fabric.sv
// ============================================================================
// Module  : mem_bus_fabric
// Brief   : N-slave decode/response fabric for the picorv32 native memory bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_fabric
    import mem_bus_pkg::*;
#(
    parameter int                            NUM_SLAVES     = 4,
    parameter int                            DATA_W         = 32,
    parameter int                            ADDR_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE       = {4{32'h0}},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_MASK       = {4{32'h0}},
    parameter int                            TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0]             ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_valid,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    output logic                         m_ready,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [NUM_SLAVES-1:0]        s_valid,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic                         err_clr,
    output logic                         err_irq,
    output logic                         err_sticky,
    output logic [ADDR_W-1:0]            err_addr,
    output logic                         err_timeout
);

    localparam int STRB_W = strb_w(DATA_W);
    localparam int CNT_W  = cnt_w(TIMEOUT_CYCLES);

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_m_ready;
    logic [DATA_W-1:0]   r_m_rdata;
    logic                r_err_irq;
    logic                r_err_sticky;
    logic [ADDR_W-1:0]   r_err_addr;
    logic                r_err_timeout;

    logic                w_hit;
    logic [SEL_W-1:0]    w_sel;
    logic                w_rdy;
    logic [DATA_W-1:0]   w_srdata;
    logic                w_timeout;

    mem_bus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .i_addr (m_addr),
        .o_hit  (w_hit),
        .o_sel  (w_sel)
    );

    // Only the latched slave is visible; other ready/rdata lanes are ignored.
    always_comb begin
        s_valid  = '0;
        w_rdy    = 1'b0;
        w_srdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel == SEL_W'(i)) begin
                s_valid[i] = (r_state == ST_ACCESS);
                w_rdy      = s_ready[i];
                w_srdata   = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_cnt         <= '0;
            r_m_ready     <= 1'b0;
            r_m_rdata     <= '0;
            r_err_irq     <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_err_addr    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_m_ready <= 1'b0;
            r_err_irq <= 1'b0;
            // An error recorded below overrides this clear.
            if (err_clr) begin
                r_err_sticky <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (m_valid) begin
                        if (w_hit) begin
                            r_sel   <= w_sel;
                            r_cnt   <= '0;
                            r_state <= ST_ACCESS;
                        end else begin
                            r_m_rdata     <= ERR_DATA;
                            r_m_ready     <= 1'b1;
                            r_err_irq     <= 1'b1;
                            r_err_sticky  <= 1'b1;
                            r_err_addr    <= m_addr;
                            r_err_timeout <= 1'b0;
                            r_state       <= ST_DONE;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_rdy) begin
                        r_m_rdata <= w_srdata;
                        r_m_ready <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (w_timeout) begin
                        r_m_rdata     <= ERR_DATA;
                        r_m_ready     <= 1'b1;
                        r_err_irq     <= 1'b1;
                        r_err_sticky  <= 1'b1;
                        r_err_addr    <= m_addr;
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ready     = r_m_ready;
    assign m_rdata     = r_m_rdata;
    assign s_addr      = m_addr;
    assign s_wdata     = m_wdata;
    assign s_wstrb     = STRB_W'(m_wstrb);
    assign err_irq     = r_err_irq;
    assign err_sticky  = r_err_sticky;
    assign err_addr    = r_err_addr;
    assign err_timeout = r_err_timeout;

endmodule

`default_nettype wire
